// File: rtl/rv32_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow can take a two-cycle fast path.
module rv32_div_unit #(
  parameter bit EARLY_OUT = 1'b1,
  parameter int ITER      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        dvd_neg_q, dvd_neg_d;
  logic        dsr_neg_q, dsr_neg_d;
  logic        div_zero_q, div_zero_d;
  logic        ovf_q, ovf_d;
  logic [31:0] dvd_raw_q, dvd_raw_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] result_q, result_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        is_signed;
  logic [31:0] dvd_abs;
  logic [31:0] dsr_abs;
  logic        div_zero_in;
  logic        ovf_in;
  logic [32:0] rem_trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dvd_neg_d  = dvd_neg_q;
    dsr_neg_d  = dsr_neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    dvd_raw_d  = dvd_raw_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    result_d   = result_q;
    cnt_d      = cnt_q;

    is_signed   = ~op[0];
    dvd_abs     = (is_signed && dividend[31]) ? -dividend : dividend;
    dsr_abs     = (is_signed && divisor[31])  ? -divisor  : divisor;
    div_zero_in = (divisor == 32'h0);
    ovf_in      = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

    // Bit 32 of the trial difference is set exactly when the divisor does not fit.
    rem_trial = {rem_q, quo_q[31]} - {1'b0, dsr_q};
    quo_fix   = (~op_q[0] && (dvd_neg_q ^ dsr_neg_q)) ? -quo_q : quo_q;
    rem_fix   = (~op_q[0] && dvd_neg_q) ? -rem_q : rem_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            op_d       = op;
            dvd_neg_d  = is_signed & dividend[31];
            dsr_neg_d  = is_signed & divisor[31];
            div_zero_d = div_zero_in;
            ovf_d      = ovf_in;
            dvd_raw_d  = dividend;
            quo_d      = dvd_abs;
            rem_d      = 32'h0;
            dsr_d      = dsr_abs;
            cnt_d      = 6'd0;
            state_d    = (EARLY_OUT && (div_zero_in || ovf_in)) ? FIN : CALC;
          end
        end
        CALC: begin
          if (!rem_trial[32]) begin
            rem_d = rem_trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = {rem_q[30:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(ITER - 1)) state_d = FIN;
        end
        FIN: begin
          if (div_zero_q)   result_d = op_q[1] ? dvd_raw_q : 32'hFFFF_FFFF;
          else if (ovf_q)   result_d = op_q[1] ? 32'h0 : 32'h8000_0000;
          else if (op_q[1]) result_d = rem_fix;
          else              result_d = quo_fix;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      dvd_neg_q  <= 1'b0;
      dsr_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      dvd_raw_q  <= 32'h0;
      quo_q      <= 32'h0;
      rem_q      <= 32'h0;
      dsr_q      <= 32'h0;
      result_q   <= 32'h0;
      cnt_q      <= 6'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dvd_neg_q  <= dvd_neg_d;
      dsr_neg_q  <= dsr_neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      dvd_raw_q  <= dvd_raw_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dsr_q      <= dsr_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIN);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
